// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NCH independent programmable tick generators sharing one clock.
// Each channel divides clk by a run-time divisor D. It emits a one-cycle tick
// per period and, optionally, a 50% square wave.
// A written divisor is held as pending and swapped in only at a period boundary.
// A channel that is stopped (disabled, or running D=0) takes it at the next edge.
// Optional feature: define MULTI_TICK_GEN_SQ_EN to build the square-wave toggle
// flops; otherwise sq is tied to 0.
module multi_tick_gen #(
  parameter int NCH     = 4,
  parameter int CW      = 20,
  parameter int DEF_DIV = 50000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NCH-1:0]                       en,
  input  logic                                 sync_clr,
  input  logic                                 wr_en,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [CW-1:0]                        wr_div,
  output logic [NCH-1:0]                       tick,
  output logic [NCH-1:0]                       sq,
  output logic [NCH-1:0]                       pend
);

  localparam int            CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] DEF_D = CW'(DEF_DIV);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] pdiv_q, pdiv_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          wr_hit, running, wrap, new_pend, activate;
    logic [CW-1:0] new_pdiv;

    // Out-of-range channel indices never match any channel, so they are dropped.
    assign wr_hit   = wr_en && (wr_ch == CHW'(i));
    assign running  = en[i] && (act_q != '0);
    // act_q is non-zero whenever running, so act_q - 1 cannot underflow.
    assign wrap     = running && (cnt_q == act_q - CW'(1));
    // A write on this edge is merged in first, so it can activate on this same edge.
    assign new_pend = wr_hit || pend_q;
    assign new_pdiv = wr_hit ? wr_div : pdiv_q;
    assign activate = new_pend && (wrap || !running);

    // Next-state: sync_clr outranks activation, which outranks counting.
    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      pdiv_d = new_pdiv;
      pend_d = pend_q;
      tick_d = 1'b0;
      if (sync_clr) begin
        cnt_d  = '0;
        act_d  = new_pdiv;
        pend_d = 1'b0;
        tick_d = 1'b0;
      end else begin
        act_d  = activate ? new_pdiv : act_q;
        pend_d = new_pend && !activate;
        tick_d = wrap;
        cnt_d  = (running && !wrap) ? cnt_q + CW'(1) : '0;
      end
    end

    // Channel state registers with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        act_q  <= DEF_D;
        pdiv_q <= DEF_D;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pdiv_q <= pdiv_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
      end
    end

    assign tick[i] = tick_q;
    assign pend[i] = pend_q;

`ifdef MULTI_TICK_GEN_SQ_EN
    logic sq_q, sq_d;

    // Square wave flips on every wrap; sync_clr forces it low.
    always_comb begin
      sq_d = sq_q ^ wrap;
      if (sync_clr) sq_d = 1'b0;
    end

    // Square-wave toggle flop.
    always_ff @(posedge clk) begin
      if (rst) sq_q <= 1'b0;
      else     sq_q <= sq_d;
    end

    assign sq[i] = sq_q;
`else
    assign sq[i] = 1'b0;
`endif
  end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 The block SHALL provide parameter NCH, default 4, meaning the number of independent tick channels (1..16).
REQ-002 The block SHALL provide parameter CW, default 20, meaning the divisor and counter width in bits.
REQ-003 The block SHALL provide parameter DEF_DIV, default 50000, meaning the divisor loaded into every channel at reset (must fit CW bits).
REQ-004 The block SHALL provide port clk, input, width 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL provide port rst, input, width 1, meaning a synchronous, active-high reset.
REQ-006 The block SHALL provide port en, input, width NCH, meaning the per-channel run enable.
REQ-007 The block SHALL provide port sync_clr, input, width 1, meaning a phase-align pulse that restarts all channels together.
REQ-008 The block SHALL provide port wr_en, input, width 1, meaning a divisor write strobe.
REQ-009 The block SHALL provide port wr_ch, input, width $clog2(NCH) (min 1), meaning the channel index of the write.
REQ-010 The block SHALL provide port wr_div, input, width CW, meaning the divisor value D to write.
REQ-011 The block SHALL provide port tick, output, width NCH, meaning a registered one-cycle pulse per channel period.
REQ-012 The block SHALL provide port sq, output, width NCH, meaning a registered 50% square wave per channel.
REQ-013 The block SHALL provide port pend, output, width NCH, meaning a written divisor not yet active.

Function
REQ-014 Each channel SHALL hold an active divisor, a pending divisor, and a CW-bit counter.
REQ-015 Enabled channel with active D>=2: counter counts 0..D-1 and wraps; tick SHALL be high for exactly the one cycle following the edge at which the counter equals D-1; period D cycles.
REQ-016 First tick after en rises SHALL occur D edges after the first edge sampling en=1; the counter starts from 0.
REQ-017 Active D=1 SHALL give tick constantly high while enabled; active D=0 SHALL stop the channel (tick low, sq held, counter 0).
REQ-018 sq SHALL toggle on every tick, giving frequency f_clk/(2D); with DEF_DIV=50000 at 100 MHz this is 1 kHz.
REQ-019 en low SHALL clear the counter to 0 and force tick low the next cycle; sq SHALL hold its value.
REQ-020 A write SHALL store wr_div into pending[wr_ch] and set pend[wr_ch]; wr_ch >= NCH SHALL be ignored.
REQ-021 The pending divisor SHALL become active at the channel's next wrap edge, or immediately at the next edge if the channel is disabled or its active D is 0; pend SHALL clear on that edge.
REQ-022 A write landing on the wrap edge SHALL become active at that same edge and govern the following period (no half-length period, no glitch).
REQ-023 Back-to-back writes to one channel before activation: the last value SHALL win.
REQ-024 sync_clr SHALL, on the next edge, zero all counters, clear tick and sq, load every pending divisor into active, and clear all pend bits.
REQ-025 Priority SHALL be rst > sync_clr > write-activation > count/wrap; a write coinciding with sync_clr SHALL be applied as active in that edge.
REQ-026 Counter arithmetic SHALL be unsigned CW-bit; comparison uses active D-1 with no overflow for D = 2^CW-1.

Reset
REQ-027 With rst high at an edge: counters 0, active and pending divisors = DEF_DIV, tick 0, sq 0, pend 0.
REQ-028 Reset asserted mid-period SHALL abort the period with no tick emitted on the reset edge or the edge after it.

Configuration
REQ-029 Macro MULTI_TICK_GEN_SQ_EN defined: sq outputs and toggle flops SHALL be implemented per REQ-018.
REQ-030 Macro MULTI_TICK_GEN_SQ_EN undefined: sq SHALL be tied to constant 0 and no toggle flops synthesised; all other behaviour unchanged.

Verification
REQ-031 Reset with NCH=4, DEF_DIV=5, en=4'b1111 -> tick[0..3] pulse aligned, first pulse 5 edges after reset release, then every 5 cycles; sq period 10 cycles.
REQ-032 Write D=3 to ch1 mid-period -> pend[1]=1 until the current 5-cycle period wraps, then ch1 ticks every 3 cycles with no short period.
REQ-033 Write D=7 to ch2 exactly on its wrap edge -> the next ch2 period is 7 cycles; pend[2] is never seen high.
REQ-034 Channels at D=3 and D=4 free-running, pulse sync_clr -> both counters restart; common ticks every 12 cycles from the clear edge.
REQ-035 Write D=0 to ch3 while enabled, then D=1 -> ch3 stops at the wrap (tick 0, sq held), then tick is continuously high from the next edge.
REQ-036 Assert rst for 1 cycle mid-period with sync_clr and wr_en also high -> all outputs are 0, divisors = DEF_DIV, and the write is discarded.
